// File: rtl/pong_fb_pkg.sv
// Shared defaults, block geometry helpers and FSM encoding for the double-buffered pong framebuffer.
// The CLEAR state exists only when PONG_FB_CLEAR_ON_SWAP_EN is defined.
package pong_fb_pkg;

  localparam int H_PIXELS_DEF = 640;
  localparam int V_PIXELS_DEF = 480;
  localparam int BLOCK_DEF    = 20;
  localparam int COLOR_W_DEF  = 12;
  localparam int COLS_DEF     = H_PIXELS_DEF / BLOCK_DEF;
  localparam int ROWS_DEF     = V_PIXELS_DEF / BLOCK_DEF;
  localparam int DEPTH_DEF    = COLS_DEF * ROWS_DEF;

  typedef logic [COLOR_W_DEF-1:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1
`ifdef PONG_FB_CLEAR_ON_SWAP_EN
    ,
    ST_CLEAR   = 2'd2
`endif
  } fb_state_e;

  // Both buffers live in one array, so the address spans 2*depth words.
  function automatic int fb_addr_w(input int depth);
    return $clog2(2 * depth);
  endfunction

  // Pixel counter to block index; blk is a constant, so this folds to a constant divider.
  function automatic int blk_idx(input int cnt, input int blk);
    return cnt / blk;
  endfunction

endpackage

// File: rtl/pong_fb_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// Kept separate so the storage maps cleanly onto block RAM.
module pong_fb_ram
  import pong_fb_pkg::*;
#(
  parameter int DATA_W = COLOR_W_DEF,
  parameter int ADDR_W = fb_addr_w(DEPTH_DEF),
  parameter int WORDS  = 2 * DEPTH_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and read register have no reset, otherwise it cannot map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pong_frame_buffer_db.sv
// Double-buffered block framebuffer: VGA reader scans the front buffer, game logic writes the back.
// Swaps happen only at frame start; define PONG_FB_CLEAR_ON_SWAP_EN to clear the new back buffer.
module pong_frame_buffer_db
  import pong_fb_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF,
  parameter int BLOCK    = BLOCK_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int CNT_W    = 10,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  localparam int COLS   = H_PIXELS / BLOCK,
  localparam int ROWS   = V_PIXELS / BLOCK,
  localparam int DEPTH  = COLS * ROWS,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int ADDR_W = fb_addr_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   hc,
  input  logic [CNT_W-1:0]   vc,
  output logic [COLOR_W-1:0] color_out,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wr_col,
  input  logic [ROW_W-1:0]   wr_row,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ready,
  input  logic               swap_req,
  output logic               swap_pending,
  output logic               swap_done,
  output logic               front_sel
);

  function automatic logic [ADDR_W-1:0] word_addr(input logic sel, input int offset);
    return ADDR_W'((sel ? DEPTH : 0) + offset);
  endfunction

  fb_state_e          state_q, state_d;
  logic               front_sel_q, front_sel_d;
  logic               swap_pending_q, swap_pending_d;
  logic               swap_done_q, swap_done_d;
  logic               in_range_q, in_range_d;
  logic               frame_start, col_ok, row_ok, clearing;
  int                 clr_offset;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic               wr_we;
  logic [COLOR_W-1:0] wr_data, rd_data;

  assign frame_start = (hc == '0) && (vc == '0);

  // A full-width index cannot exceed the grid, so only partial widths need a bound check.
  if (COLS == (1 << COL_W)) begin : g_col_full
    assign col_ok = 1'b1;
  end else begin : g_col_part
    assign col_ok = (wr_col < COL_W'(COLS));
  end
  if (ROWS == (1 << ROW_W)) begin : g_row_full
    assign row_ok = 1'b1;
  end else begin : g_row_part
    assign row_ok = (wr_row < ROW_W'(ROWS));
  end

`ifdef PONG_FB_CLEAR_ON_SWAP_EN
  localparam int CLR_W = $clog2(DEPTH);
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  assign clearing   = (state_q == ST_CLEAR);
  assign clr_offset = int'(clr_cnt_q);
`else
  assign clearing   = 1'b0;
  assign clr_offset = 0;
`endif

  assign wr_ready = ~clearing;

  always_comb begin
    in_range_d = (hc < CNT_W'(H_PIXELS)) && (vc < CNT_W'(V_PIXELS));
    rd_addr    = '0;
    if (in_range_d) begin
      rd_addr = word_addr(front_sel_q,
                          blk_idx(int'(vc), BLOCK) * COLS + blk_idx(int'(hc), BLOCK));
    end
  end

  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    wr_we   = 1'b0;
    wr_addr = '0;
    wr_data = wr_color;
    if (clearing) begin
      wr_we   = 1'b1;
      wr_addr = word_addr(~front_sel_q, clr_offset);
      wr_data = CLEAR_COLOR;
    end else if (wr_en && wr_ready && col_ok && row_ok) begin
      wr_we   = 1'b1;
      wr_addr = word_addr(~front_sel_q, int'(wr_row) * COLS + int'(wr_col));
    end
  end

  always_comb begin
    state_d        = state_q;
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    swap_done_d    = 1'b0;
`ifdef PONG_FB_CLEAR_ON_SWAP_EN
    clr_cnt_d      = clr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          state_d        = ST_PENDING;
          swap_pending_d = 1'b1;
        end
      end
      ST_PENDING: begin
        // Later swap_req pulses fall through here and are absorbed.
        if (frame_start) begin
          front_sel_d    = ~front_sel_q;
          swap_pending_d = 1'b0;
          swap_done_d    = 1'b1;
`ifdef PONG_FB_CLEAR_ON_SWAP_EN
          state_d        = ST_CLEAR;
          clr_cnt_d      = '0;
`else
          state_d        = ST_IDLE;
`endif
        end
      end
`ifdef PONG_FB_CLEAR_ON_SWAP_EN
      ST_CLEAR: begin
        if (swap_req) swap_pending_d = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_W'(DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = (swap_pending_q || swap_req) ? ST_PENDING : ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef PONG_FB_CLEAR_ON_SWAP_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      in_range_q     <= 1'b0;
    end else begin
`ifdef PONG_FB_CLEAR_ON_SWAP_EN
      clr_cnt_q <= clr_cnt_d;
`endif
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      in_range_q     <= in_range_d;
    end
  end

  pong_fb_ram #(
    .DATA_W (COLOR_W),
    .ADDR_W (ADDR_W),
    .WORDS  (2 * DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign color_out    = in_range_q ? rd_data : '0;
  assign front_sel    = front_sel_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_pong_frame_buffer_db.sv
// Scoreboard bench for pong_frame_buffer_db: stimulus pushes due-cycle expectations, a negedge monitor compares.
// Runs the clear-on-swap sequence instead when PONG_FB_CLEAR_ON_SWAP_EN is defined.
module tb_pong_frame_buffer_db;
  import pong_fb_pkg::*;

  localparam int     CNT_W       = 10;
  localparam int     COL_W       = $clog2(COLS_DEF);
  localparam int     ROW_W       = $clog2(ROWS_DEF);
  localparam color_t CLEAR_COLOR = 12'h000;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] hc, vc;
  color_t           color_out;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  color_t           wr_color;
  logic             wr_ready, swap_req, swap_pending, swap_done, front_sel;

  always #5 clk = ~clk;

  pong_frame_buffer_db dut (
    .clk          (clk),
    .rst          (rst),
    .hc           (hc),
    .vc           (vc),
    .color_out    (color_out),
    .wr_en        (wr_en),
    .wr_col       (wr_col),
    .wr_row       (wr_row),
    .wr_color     (wr_color),
    .wr_ready     (wr_ready),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_sel    (front_sel)
  );

  typedef enum {K_COLOR, K_FRONT, K_PEND, K_DONE, K_READY, K_NDONE} kind_e;
  typedef struct {
    int    due;
    kind_e kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   ndone = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_COLOR: return 32'(color_out);
      K_FRONT: return 32'(front_sel);
      K_PEND:  return 32'(swap_pending);
      K_DONE:  return 32'(swap_done);
      K_READY: return 32'(wr_ready);
      K_NDONE: return 32'(ndone);
      default: return '0;
    endcase
  endfunction

  // Monitor: counts swap_done pulses, then retires every expectation that has come due.
  always @(negedge clk) begin
    if (swap_done === 1'b1) ndone++;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        check(sb_q[i].name, sample(sb_q[i].kind), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic expect_at(input int dly, input kind_e k, input int v, input string nm);
    sb_q.push_back('{due: cyc + dly, kind: k, exp: v, name: nm});
  endtask

  task automatic park();
    hc = 10'd700;
    vc = 10'd500;
  endtask

  task automatic frame_start();
    hc = '0;
    vc = '0;
  endtask

  task automatic write_blk(input int col, input int row, input color_t c);
    wr_en    = 1'b1;
    wr_col   = COL_W'(col);
    wr_row   = ROW_W'(row);
    wr_color = c;
    step();
  endtask

  task automatic read_chk(input int h, input int v, input color_t exp, input string nm);
    hc = CNT_W'(h);
    vc = CNT_W'(v);
    expect_at(1, K_COLOR, int'(exp), nm);
    step();
    park();
  endtask

  task automatic fill_buf(input int base, input int mul);
    for (int r = 0; r < ROWS_DEF; r++)
      for (int c = 0; c < COLS_DEF; c++)
        write_blk(c, r, color_t'(base + mul * (r * COLS_DEF + c)));
  endtask

  // Reads every block at its top-left pixel, so the first read sits on the frame-start point.
  task automatic read_all(input int base, input int mul, input int oc, input int orow,
                          input color_t ov, input string tag);
    color_t e;
    for (int r = 0; r < ROWS_DEF; r++)
      for (int c = 0; c < COLS_DEF; c++) begin
        e = (c == oc && r == orow) ? ov : color_t'(base + mul * (r * COLS_DEF + c));
        read_chk(c * BLOCK_DEF, r * BLOCK_DEF, e, $sformatf("%s_r%0d_c%0d", tag, r, c));
      end
  endtask

`ifdef PONG_FB_CLEAR_ON_SWAP_EN
  // Counts cycles with wr_ready low; attempts a write on the last cleared cycle.
  task automatic count_clear(input bit req_mid, output int cnt);
    cnt = 0;
    while (!wr_ready && cnt < 4 * DEPTH_DEF) begin
      cnt++;
      if (cnt == 100 && req_mid) swap_req = 1'b1;
      if (cnt == DEPTH_DEF) begin
        wr_en    = 1'b1;
        wr_col   = COL_W'(3);
        wr_row   = ROW_W'(2);
        wr_color = 12'h0A5;
      end
      step();
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_col   = '0;
    wr_row   = '0;
    wr_color = '0;
    swap_req = 1'b0;
    park();

`ifndef PONG_FB_CLEAR_ON_SWAP_EN
    hc = 10'd70;
    vc = 10'd45;
    expect_at(1, K_FRONT, 0, "rst_front");
    expect_at(1, K_PEND,  0, "rst_pending");
    expect_at(1, K_DONE,  0, "rst_done");
    expect_at(1, K_READY, 1, "rst_ready");
    expect_at(1, K_COLOR, 0, "rst_color");
    step();
    step();
    rst = 1'b0;
    park();

    // Buffer 1 gets 0x800+index, block (3,2) overridden with red.
    fill_buf(12'h800, 1);
    write_blk(3, 2, 12'hF00);
    swap_req = 1'b1;
    expect_at(1, K_PEND,  1, "req_pending");
    expect_at(1, K_FRONT, 0, "req_front_held");
    step();
    step();
    frame_start();
    expect_at(1, K_DONE,  1, "swap1_done");
    expect_at(1, K_FRONT, 1, "swap1_front");
    expect_at(1, K_PEND,  0, "swap1_pend_clr");
    expect_at(2, K_DONE,  0, "swap1_done_low");
    step();
    park();
    read_chk(60, 40, 12'hF00, "blk32_tl");
    read_chk(79, 59, 12'hF00, "blk32_br");
    read_chk(70, 50, 12'hF00, "blk32_mid");
    read_chk(80, 40, 12'h844, "blk42");
    read_chk(59, 40, 12'h842, "blk22");
    read_chk(60, 60, 12'h863, "blk33");
    read_chk(639, 479, 12'hAFF, "blk_last");
    read_chk(640, 100, 12'h000, "hc_oob");
    read_chk(10, 480, 12'h000, "vc_oob");
    expect_at(1, K_NDONE, 1, "ndone_after_swap1");
    step();

    // Buffer 0 (back) gets 0x400+index; out-of-grid rows must not alias into the front.
    fill_buf(12'h400, 1);
    write_blk(3, 2, 12'h0A5);
    write_blk(3, 30, 12'hBAD);
    write_blk(0, 24, 12'hBAD);
    read_chk(65, 125, 12'h8C3, "oob_row30_front");
    read_chk(5, 5, 12'h800, "oob_row24_front");
    read_all(12'h800, 1, 3, 2, 12'hF00, "noswap");
    expect_at(1, K_FRONT, 1, "noswap_front");
    expect_at(1, K_NDONE, 1, "noswap_ndone");
    step();

    // Request on the frame-start edge only latches.
    frame_start();
    swap_req = 1'b1;
    expect_at(1, K_COLOR, 12'h800, "req_at_fs_color");
    expect_at(1, K_PEND,  1, "req_at_fs_pend");
    expect_at(1, K_FRONT, 1, "req_at_fs_front");
    expect_at(1, K_DONE,  0, "req_at_fs_nodone");
    step();
    park();
    for (int i = 0; i < 3; i++) begin
      swap_req = 1'b1;
      step();
      step();
    end
    expect_at(1, K_NDONE, 1, "absorb_ndone");
    expect_at(1, K_PEND,  1, "absorb_pend");
    step();
    frame_start();
    expect_at(1, K_COLOR, 12'h800, "swap_edge_old_front");
    expect_at(1, K_FRONT, 0, "swap2_front");
    expect_at(1, K_DONE,  1, "swap2_done");
    step();
    expect_at(1, K_COLOR, 12'h400, "post_swap_color");
    expect_at(1, K_DONE,  0, "swap2_done_low");
    expect_at(1, K_NDONE, 2, "single_toggle");
    expect_at(1, K_FRONT, 0, "no_second_toggle");
    step();
    park();
    read_chk(70, 45, 12'h0A5, "back_write_shown");
    read_chk(65, 125, 12'h4C3, "buf0_blk36");
    read_chk(639, 479, 12'h6FF, "buf0_last");

    // Reset while pending drops the swap and returns to buffer 0.
    swap_req = 1'b1;
    step();
    frame_start();
    expect_at(1, K_FRONT, 1, "swap3_front");
    step();
    park();
    swap_req = 1'b1;
    expect_at(1, K_PEND, 1, "pend_before_rst");
    step();
    rst = 1'b1;
    hc  = 10'd70;
    vc  = 10'd45;
    expect_at(1, K_FRONT, 0, "rst_mid_front");
    expect_at(1, K_PEND,  0, "rst_mid_pend");
    expect_at(1, K_COLOR, 0, "rst_mid_color");
    step();
    rst = 1'b0;
    frame_start();
    expect_at(1, K_DONE,  0, "rst_no_done");
    expect_at(2, K_NDONE, 3, "rst_ndone");
    expect_at(2, K_FRONT, 0, "rst_front_kept");
    step();
    park();
    step();
    step();
`else
    expect_at(1, K_READY, 0, "rst_ready_low");
    expect_at(1, K_FRONT, 0, "rst_front");
    expect_at(1, K_PEND,  0, "rst_pending");
    step();
    rst = 1'b0;
    count_clear(1'b0, n);
    check("rst_clear_len", n, DEPTH_DEF);

    fill_buf(12'hABC, 0);
    swap_req = 1'b1;
    step();
    frame_start();
    expect_at(1, K_FRONT, 1, "clr_swap1_front");
    expect_at(1, K_READY, 0, "clr_ready_low");
    step();
    park();
    count_clear(1'b1, n);
    check("swap_clear_len", n, DEPTH_DEF);
    expect_at(0, K_PEND, 1, "clr_req_latched");
    frame_start();
    expect_at(1, K_FRONT, 0, "clr_swap2_front");
    step();
    park();
    count_clear(1'b0, n);
    check("swap2_clear_len", n, DEPTH_DEF);
    read_all(int'(CLEAR_COLOR), 0, -1, -1, CLEAR_COLOR, "clr_buf0");

    swap_req = 1'b1;
    step();
    frame_start();
    expect_at(1, K_FRONT, 1, "clr_swap3_front");
    step();
    park();
    read_all(int'(CLEAR_COLOR), 0, -1, -1, CLEAR_COLOR, "clr_buf1");
    step();
`endif

    check("sb_drain", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
